// File: rtl/dmem_responder.sv
// dmem_responder: target end of the RV32I core's data-memory interface.
// Byte-lane stores into a word-organised array; loads return sign- or
// zero-extended data one cycle after the access edge. Misaligned accesses
// and reserved width codes are suppressed and flagged on misalign.
module dmem_responder #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [2:0]  memop,
  input  logic        we,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        misalign
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101
  } memop_e;

  // Word array, lane k holds byte offset k (little-endian).
  logic [31:0] mem [WORDS];

  logic [ADDR_WIDTH-3:0] word_idx;
  logic [1:0]            offset;
  logic                  bad;
  logic [3:0]            byte_en;
  logic [31:0]           wdata;

  // Registered load stage: word read on the edge plus the select controls.
  logic [31:0] rd_word_q;
  memop_e      op_q;
  logic [1:0]  off_q;
  logic        zero_q;

  // Address bits above the decoded range alias and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH];

  assign word_idx = addr[ADDR_WIDTH-1:2];
  assign offset   = addr[1:0];

  // Alignment check on the width code and the low address bits.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    bad = 1'b1;
    case (memop)
      OP_LB, OP_LBU: bad = 1'b0;
      OP_LH, OP_LHU: bad = offset[0];
      OP_LW:         bad = (offset != 2'b00);
      default:       bad = 1'b1;
    endcase
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    byte_en = 4'b0000;
    wdata   = datain;
    case (memop[1:0])
      2'b00: begin
        byte_en = 4'b0001 << offset;
        wdata   = {4{datain[7:0]}};
      end
      2'b01: begin
        byte_en = offset[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{datain[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wdata   = datain;
      end
      default: byte_en = 4'b0000;
    endcase
  end

  // Byte-lane writes for good stores; nothing is written while in reset.
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset branch; clearing it would turn a RAM
    // into thousands of flops, and its contents are meant to survive reset.
    if (!reset && we && !bad) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  // Load stage and misalign flag; stores leave the load result untouched.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      rd_word_q <= 32'h0;
      op_q      <= OP_LW;
      off_q     <= 2'b00;
      zero_q    <= 1'b1;
      misalign  <= 1'b0;
    end else begin
      misalign <= bad;
      if (!we) begin
        zero_q <= bad;
        if (!bad) begin
          rd_word_q <= mem[word_idx];
          op_q      <= memop_e'(memop);
          off_q     <= offset;
        end
      end
    end
  end

  // Output stage: select and extend from the registered word and controls.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rd_word_q[7:0];
    case (off_q)
      2'd0: sel_byte = rd_word_q[7:0];
      2'd1: sel_byte = rd_word_q[15:8];
      2'd2: sel_byte = rd_word_q[23:16];
      2'd3: sel_byte = rd_word_q[31:24];
      default: sel_byte = rd_word_q[7:0];
    endcase
    sel_half = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

    dataout = 32'h0;
    if (!zero_q) begin
      case (op_q)
        OP_LB:   dataout = {{24{sel_byte[7]}}, sel_byte};
        OP_LBU:  dataout = {24'h0, sel_byte};
        OP_LH:   dataout = {{16{sel_half[15]}}, sel_half};
        OP_LHU:  dataout = {16'h0, sel_half};
        OP_LW:   dataout = rd_word_q;
        default: dataout = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: expected results are queued as each access
// is driven and compared right after the edge that produces them.
module tb_dmem_responder;

  localparam int AW = 15;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] RSV = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] RS6 = 3'b110;

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic [2:0]  memop;
  logic        we;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        misalign;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  dmem_responder #(.ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .memop    (memop),
    .we       (we),
    .datain   (datain),
    .dataout  (dataout),
    .misalign (misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one access, queue its expected result, and advance past the edge.
  task automatic access(input logic w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d, input logic exp_m);
    we     = w;
    memop  = op;
    addr   = a;
    datain = d;
    sb_q.push_back('{data: exp_d, mis: exp_m});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin reset = 1'b1; access(1'b0, LW, 32'h0, 32'h0, 32'h0, 1'b0); end
        1: begin reset = 1'b0; access(1'b1, LW, 32'h0, 32'h0BADF00D, 32'h0, 1'b0); end
        2: access(1'b0, LW, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);
        3: access(1'b1, LW, 32'h2, 32'hDEADBEEF, 32'h0BADF00D, 1'b1);
        4: begin reset = 1'b1; access(1'b1, LW, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0); end
        5: access(1'b1, LW, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
        default: begin reset = 1'b0; access(1'b0, LW, 32'h0, 32'h0, 32'h0BADF00D, 1'b0); end
      endcase
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL reset step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        if (dataout !== e.data || misalign !== e.mis) begin
          failures++;
          $display("FAIL reset step %0d: got dataout=%h misalign=%b, need dataout=%h misalign=%b",
                   i, dataout, misalign, e.data, e.mis);
        end
      end
    end
  endtask

  task automatic test_word_and_byte();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: access(1'b1, LW, 32'h100, 32'h12345678, 32'h0BADF00D, 1'b0);
        1: access(1'b0, LW, 32'h100, 32'h0, 32'h12345678, 1'b0);
        2: access(1'b1, LB, 32'h101, 32'h555555AB, 32'h12345678, 1'b0);
        3: access(1'b0, LW, 32'h100, 32'h0, 32'h1234AB78, 1'b0);
        4: access(1'b0, LB, 32'h101, 32'h0, 32'hFFFFFFAB, 1'b0);
        default: access(1'b0, LBU, 32'h101, 32'h0, 32'h000000AB, 1'b0);
      endcase
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL word_byte step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        if (dataout !== e.data || misalign !== e.mis) begin
          failures++;
          $display("FAIL word_byte step %0d: got dataout=%h misalign=%b, need dataout=%h misalign=%b",
                   i, dataout, misalign, e.data, e.mis);
        end
      end
    end
  endtask

  task automatic test_half();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: access(1'b1, LH, 32'h102, 32'h77778001, 32'h000000AB, 1'b0);
        1: access(1'b0, LH, 32'h102, 32'h0, 32'hFFFF8001, 1'b0);
        2: access(1'b0, LHU, 32'h102, 32'h0, 32'h00008001, 1'b0);
        3: access(1'b0, LW, 32'h100, 32'h0, 32'h8001AB78, 1'b0);
        4: access(1'b0, LH, 32'h100, 32'h0, 32'hFFFFAB78, 1'b0);
        default: access(1'b0, LBU, 32'h103, 32'h0, 32'h00000080, 1'b0);
      endcase
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL half step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        if (dataout !== e.data || misalign !== e.mis) begin
          failures++;
          $display("FAIL half step %0d: got dataout=%h misalign=%b, need dataout=%h misalign=%b",
                   i, dataout, misalign, e.data, e.mis);
        end
      end
    end
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: access(1'b1, LW, 32'h104, 32'hCAFEF00D, 32'h00000080, 1'b0);
        1: access(1'b1, LW, 32'h105, 32'hFFFFFFFF, 32'h00000080, 1'b1);
        2: access(1'b1, RS6, 32'h104, 32'h11111111, 32'h00000080, 1'b1);
        3: access(1'b0, LW, 32'h104, 32'h0, 32'hCAFEF00D, 1'b0);
        4: access(1'b0, LH, 32'h103, 32'h0, 32'h0, 1'b1);
        5: access(1'b0, LW, 32'h100, 32'h0, 32'h8001AB78, 1'b0);
        6: access(1'b0, RSV, 32'h100, 32'h0, 32'h0, 1'b1);
        7: access(1'b0, LB, 32'h100, 32'h0, 32'h00000078, 1'b0);
        8: access(1'b1, LB, (32'h1 << AW) - 32'h1, 32'h00000080, 32'h00000078, 1'b0);
        default: access(1'b0, LB, (32'h1 << AW) - 32'h1, 32'h0, 32'hFFFFFF80, 1'b0);
      endcase
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL misalign step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        if (dataout !== e.data || misalign !== e.mis) begin
          failures++;
          $display("FAIL misalign step %0d: got dataout=%h misalign=%b, need dataout=%h misalign=%b",
                   i, dataout, misalign, e.data, e.mis);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: access(1'b0, LW, 32'h100, 32'h0, 32'h8001AB78, 1'b0);
        1: access(1'b0, LW, 32'h104, 32'h0, 32'hCAFEF00D, 1'b0);
        2: access(1'b0, LW, 32'h100, 32'h0, 32'h8001AB78, 1'b0);
        3: access(1'b0, LW, 32'h100 + (32'h1 << AW), 32'h0, 32'h8001AB78, 1'b0);
        4: access(1'b1, LB, 32'hFFFF0106, 32'h0000005A, 32'h8001AB78, 1'b0);
        default: access(1'b0, LW, 32'h104, 32'h0, 32'hCA5AF00D, 1'b0);
      endcase
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL back_to_back step %0d: scoreboard empty", i);
      end else begin
        e = sb_q.pop_front();
        if (dataout !== e.data || misalign !== e.mis) begin
          failures++;
          $display("FAIL back_to_back step %0d: got dataout=%h misalign=%b, need dataout=%h misalign=%b",
                   i, dataout, misalign, e.data, e.mis);
        end
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    memop  = LW;
    addr   = 32'h0;
    datain = 32'h0;
    #2;
    test_reset();
    test_word_and_byte();
    test_half();
    test_misalign();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
